// File: rtl/iter_alu.sv
// iter_alu: single-cycle logic/arith ops plus iterative multiply/divide behind a valid/ready handshake
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] port_a,
  input  logic [WIDTH-1:0] port_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] port_out,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  state_t state, state_d;
  logic [3:0] op_q;
  logic [WIDTH-1:0] hi, lo, d, res_s, a_mag, b_mag, hi_n, lo_n, fin_raw, fin;
  logic [WIDTH:0] sum, sh;
  logic [SHW-1:0] cnt;
  logic neg_q, ovf_q, ovf_s, ovf_div, accept, div_op, multi, last, ge, q_div;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign div_op = op[3:2] == 2'b11;
  assign multi = op >= 4'd10 && !(div_op && port_b == '0);
  assign last = cnt == LAST;
  assign out_valid = state == DONE;
  assign busy = state == BUSY;
  assign negative = port_out[WIDTH-1];
  assign zero = out_valid && port_out == '0;
  assign a_mag = (op[3:1] == 3'b111 && port_a[WIDTH-1]) ? -port_a : port_a;
  assign b_mag = (op[3:1] == 3'b111 && port_b[WIDTH-1]) ? -port_b : port_b;
  assign ovf_div = op == 4'd14 && port_a == {1'b1, {(WIDTH-1){1'b0}}} && port_b == '1;
  always_comb begin
    res_s = '0;
    ovf_s = 1'b0;
    case (op)
      4'd0: begin
        res_s = port_a + port_b;
        ovf_s = port_a[WIDTH-1] == port_b[WIDTH-1] && res_s[WIDTH-1] != port_a[WIDTH-1];
      end
      4'd1: begin
        res_s = port_a - port_b;
        ovf_s = port_a[WIDTH-1] != port_b[WIDTH-1] && res_s[WIDTH-1] != port_a[WIDTH-1];
      end
      4'd2: res_s = port_a << port_b[SHW-1:0];
      4'd3: res_s = port_a >> port_b[SHW-1:0];
      4'd4: res_s = $signed(port_a) >>> port_b[SHW-1:0];
      4'd5: res_s = port_a & port_b;
      4'd6: res_s = port_a | port_b;
      4'd7: res_s = port_a ^ port_b;
      4'd8: res_s = {{(WIDTH-1){1'b0}}, $signed(port_a) < $signed(port_b)};
      4'd9: res_s = {{(WIDTH-1){1'b0}}, port_a < port_b};
      // only reached here as a zero-divisor shortcut: remainder ops return the dividend
      default: res_s = op[0] ? port_a : '1;
    endcase
  end
  // hi:lo is the product accumulator for multiply, remainder:quotient for divide
  assign q_div = op_q[3:2] == 2'b11;
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
  assign sh = {hi, lo[WIDTH-1]};
  assign ge = sh >= {1'b0, d};
  assign hi_n = q_div ? (ge ? sh[WIDTH-1:0] - d : sh[WIDTH-1:0]) : sum[WIDTH:1];
  assign lo_n = q_div ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
  assign fin_raw = op_q[0] ? hi_n : lo_n;
  assign fin = neg_q ? -fin_raw : fin_raw;
  always_ff @(posedge CLK) state <= RST ? IDLE : state_d;
  always_comb begin
    state_d = state;
    if (accept) state_d = multi ? BUSY : DONE;
    else if (state == BUSY && last) state_d = DONE;
    else if (state == DONE && out_ready) state_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      op_q <= '0;
      hi <= '0;
      lo <= '0;
      d <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      port_out <= '0;
      overflow <= 1'b0;
    end else if (accept) begin
      op_q <= op;
      cnt <= '0;
      hi <= '0;
      lo <= div_op ? a_mag : port_b;
      d <= div_op ? b_mag : port_a;
      neg_q <= op == 4'd14 ? port_a[WIDTH-1] ^ port_b[WIDTH-1] : op == 4'd15 && port_a[WIDTH-1];
      ovf_q <= ovf_div;
      if (!multi) begin
        port_out <= res_s;
        overflow <= ovf_s;
      end
    end else if (state == BUSY) begin
      hi <= hi_n;
      lo <= lo_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        port_out <= fin;
        overflow <= ovf_q;
      end
    end
  end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; SHALL be a power of two, 8..64.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  synchronous active-high reset, sampled on rising CLK.
REQ-005 in_valid  in  1  operation request valid.
REQ-006 in_ready  out  1  unit can accept a request this cycle.
REQ-007 op  in  4  operation code, encoding per REQ-012.
REQ-008 port_a, port_b  in  WIDTH  operands.
REQ-009 out_valid  out  1  result, flags held stable while high.
REQ-010 out_ready  in  1  consumer accepts result.
REQ-011 port_out  out  WIDTH  result; negative, zero, overflow  out  1 each  flags; busy  out  1  multi-cycle op in progress.

Function
REQ-012 op codes: 0 ADD, 1 SUB, 2 SLL, 3 SRL, 4 SRA, 5 AND, 6 OR, 7 XOR, 8 SLT, 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14 DIV (signed), 15 REM (signed).
REQ-013 Request accepted on rising edge with in_valid && in_ready; operands and op SHALL be captured at that edge, later input changes ignored.
REQ-014 States IDLE, BUSY, DONE; in_ready = (IDLE) || (DONE && out_ready).
REQ-015 Ops 0-9: accept -> DONE next edge; out_valid high 1 cycle after accept.
REQ-016 Ops 10-15: accept -> BUSY; exactly WIDTH iteration cycles (shift-add multiply, restoring divide on magnitudes); then DONE; out_valid high WIDTH+1 cycles after accept.
REQ-017 Divisor zero: SHALL skip BUSY, DONE next edge; DIV/DIVU quotient all-ones, REM/REMU result = port_a.
REQ-018 DIV with a = most-negative, b = -1: quotient = most-negative, REM = 0, overflow = 1; via normal WIDTH-cycle path.
REQ-019 Signed DIV quotient sign = sign(a) XOR sign(b); REM sign = sign(a); magnitude fixup applied in final iteration, no extra cycle.
REQ-020 Shifts use port_b[SHW-1:0] only; upper bits ignored.
REQ-021 SLT/SLTU result = zero-extended 1-bit compare.
REQ-022 overflow: ADD SHALL set when operand signs equal and result sign differs; SUB when operand signs differ and result sign differs from a; DIV per REQ-018; 0 otherwise.
REQ-023 negative = port_out[WIDTH-1]; zero = (port_out == 0); computed from the registered result, valid whenever out_valid.
REQ-024 DONE with out_ready low: out_valid, port_out, flags SHALL hold; in_ready low.
REQ-025 DONE && out_ready && in_valid: result retired and new request accepted same edge; no bubble for ops 0-9 (back-to-back results every cycle).
REQ-026 DONE && out_ready && !in_valid: -> IDLE, out_valid low next cycle.
REQ-027 busy = (state == BUSY); in_ready low throughout BUSY.
REQ-028 in_valid while not in_ready: request SHALL NOT be captured; requester holds it.

Reset
REQ-029 RST high at an edge: state -> IDLE, out_valid 0, busy 0, port_out 0, negative 0, zero 0, overflow 0, iteration counter 0; in_ready 1 the cycle after.
REQ-030 RST SHALL take priority over any accept or iteration, including mid-BUSY; the aborted operation SHALL produce no result.

Verification
REQ-031 WIDTH=32: ADD a=0x7FFFFFFF, b=1 -> out_valid 1 cycle later, port_out 0x80000000, overflow 1, negative 1, zero 0.
REQ-032 SUB a=5, b=5 with out_ready held high, then SLTU a=1, b=2 next cycle -> results 0 (zero 1) and 1 on consecutive cycles, in_ready continuously 1.
REQ-033 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 32 cycles, out_valid on cycle 33, port_out 0xFFFFFFFE; MUL same operands -> 0x00000001.
REQ-034 DIV a=-7, b=2 -> quotient 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU a=100, b=0 -> 0xFFFFFFFF after 1 cycle, no busy.
REQ-035 DIV a=0x80000000, b=0xFFFFFFFF -> port_out 0x80000000, overflow 1; hold out_ready low 5 cycles -> outputs stable, in_ready 0.
REQ-036 Start DIVU, assert RST at iteration 10 -> next cycle IDLE, out_valid 0, busy 0, in_ready 1; new ADD 2+3 -> port_out 5.
